// File: rtl/lane_transpose_packer.sv
// lane_transpose_packer
// Streaming column-extract transpose engine. Each accepted input word gives up one
// element (lane cfg_col, modulo the lane count) which is packed LSB-first into output
// words delivered over a valid/ready handshake. Element width is 16, 8 or 32 bits.
// Optional feature macro: LTP_STALL_CNT_EN enables the output backpressure stall counter;
// without it stall_cnt is tied to zero.
module lane_transpose_packer #(
   parameter int DATA_W = 64,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              start,
   input  logic [1:0]        cfg_mode,
   input  logic [5:0]        cfg_col,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [15:0]       stall_cnt
);

   localparam int PTR_W = $clog2(DATA_W / 8);
   localparam int SH_W  = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   function automatic int elemWidth(input logic [1:0] mode);
      case (mode)
         2'd1:    return 8;
         2'd2:    return 32;
         default: return 16;
      endcase
   endfunction

   function automatic int laneCount(input logic [1:0] mode);
      return DATA_W / elemWidth(mode);
   endfunction

   function automatic logic [PTR_W-1:0] laneOf(input logic [1:0] mode, input logic [5:0] col);
      return PTR_W'(int'(col) % laneCount(mode));
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [PTR_W-1:0]    col_q, col_d;
   logic [PTR_W-1:0]    wptr_q, wptr_d;
   logic [LEN_W-1:0]    remain_q, remain_d;
   logic [DATA_W-1:0]   packWord_q, packWord_d;
   logic [DATA_W-1:0]   outData_q, outData_d;
   logic                outValid_q, outValid_d;
   logic                outLast_q, outLast_d;

   int                  ew;
   int                  lanes;
   logic [DATA_W-1:0]   elemMask;
   logic [DATA_W-1:0]   elem;
   logic [DATA_W-1:0]   placed;
   logic                accept;
   logic                lastElem;
   logic                closeWord;

   assign in_ready  = (state_q == RUN) && (!outValid_q || out_ready);
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_last  = outLast_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

   // Extract the selected element from the input word and position it at the write lane.
   always_comb begin
      ew    = elemWidth(mode_q);
      lanes = laneCount(mode_q);
      case (mode_q)
         2'd1:    elemMask = DATA_W'(8'hFF);
         2'd2:    elemMask = DATA_W'(32'hFFFF_FFFF);
         default: elemMask = DATA_W'(16'hFFFF);
      endcase
      elem      = (in_data >> SH_W'(int'(col_q) * ew)) & elemMask;
      placed    = elem << SH_W'(int'(wptr_q) * ew);
      accept    = in_valid && in_ready;
      lastElem  = (remain_q == LEN_W'(1));
      closeWord = (int'(wptr_q) == lanes - 1) || lastElem;
   end

   // Next-state logic: job sequencing, lane packing and the output holding register.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      col_d      = col_q;
      wptr_d     = wptr_q;
      remain_d   = remain_q;
      packWord_d = packWord_q;
      outData_d  = outData_q;
      outValid_d = outValid_q;
      outLast_d  = outLast_q;

      if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
         outLast_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d     = cfg_mode;
               col_d      = laneOf(cfg_mode, cfg_col);
               remain_d   = cfg_len;
               wptr_d     = '0;
               packWord_d = '0;
               state_d    = (cfg_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (accept) begin
               remain_d = remain_q - LEN_W'(1);
               if (closeWord) begin
                  outData_d  = packWord_q | placed;
                  outValid_d = 1'b1;
                  outLast_d  = lastElem;
                  packWord_d = '0;
                  wptr_d     = '0;
               end else begin
                  packWord_d = packWord_q | placed;
                  wptr_d     = wptr_q + PTR_W'(1);
               end
               if (lastElem) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (outValid_q && out_ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (clr) begin
         state_d    = IDLE;
         outValid_d = 1'b0;
         outLast_d  = 1'b0;
         packWord_d = '0;
         wptr_d     = '0;
         remain_d   = '0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         mode_q     <= 2'd0;
         col_q      <= '0;
         wptr_q     <= '0;
         remain_q   <= '0;
         packWord_q <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
         outLast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         col_q      <= col_d;
         wptr_q     <= wptr_d;
         remain_q   <= remain_d;
         packWord_q <= packWord_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
         outLast_q  <= outLast_d;
      end
   end

`ifdef LTP_STALL_CNT_EN
   logic [15:0] stallCnt_q, stallCnt_d;

   // Saturating count of cycles the consumer holds off a valid output word.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (outValid_q && !out_ready && (stallCnt_q != 16'hFFFF)) begin
         stallCnt_d = stallCnt_q + 16'd1;
      end
      if (clr || ((state_q == IDLE) && start)) begin
         stallCnt_d = 16'd0;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stallCnt_q <= 16'd0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

   assign stall_cnt = stallCnt_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule
